// File: rtl/rob_allocator_pkg.sv
// rob_allocator_pkg: shared ROB allocator types, sizes and helpers
package rob_allocator_pkg;

    localparam int ID_SIZE_DEF          = 1;
    localparam int REG_ADDRESS_SIZE_DEF = 5;
    localparam int ROB_ENTRIES          = 1 << ID_SIZE_DEF;

    typedef logic [ID_SIZE_DEF-1:0]          rob_id_t;
    typedef logic [REG_ADDRESS_SIZE_DEF-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t addr;
        logic      w;
    } dest_entry_t;

    function automatic int popcount(input logic [63:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) n += int'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/rob_allocator_ptr_counter.sv
// rob_ptr_counter: wrapping ROB pointer with load (priority) and increment
module rob_ptr_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] ptr
);

    // load wins over increment; increment wraps naturally at 2**W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr <= '0;
        else if (load) ptr <= load_val;
        else if (inc) ptr <= ptr + W'(1);
    end

endmodule

// File: rtl/rob_allocator.sv
// rob_allocator: in-order ROB ID issuer with occupancy, busy map and dest table
module rob_allocator
    import rob_allocator_pkg::*;
#(
    parameter int ID_SIZE          = ID_SIZE_DEF,
    parameter int REG_ADDRESS_SIZE = REG_ADDRESS_SIZE_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alloc_req,
    input  logic [REG_ADDRESS_SIZE-1:0] alloc_dest_addr,
    input  logic                        alloc_w,
    output logic                        alloc_grant,
    output logic [ID_SIZE-1:0]          alloc_id,
    output logic [ID_SIZE-1:0]          tail,
    input  logic                        commit,
    input  logic                        flush,
    input  logic [ID_SIZE-1:0]          query_id,
    output logic [REG_ADDRESS_SIZE-1:0] query_addr,
    output logic                        query_w,
    output logic [(1<<ID_SIZE)-1:0]     busy,
    output logic [ID_SIZE:0]            count,
    output logic                        full,
    output logic                        empty,
    output logic                        commit_error
);

    localparam int N = 1 << ID_SIZE;
    localparam logic [ID_SIZE:0] ENTRIES = (ID_SIZE+1)'(N);

    logic [ID_SIZE-1:0]          head;
    logic                        valid_commit;
    logic [REG_ADDRESS_SIZE-1:0] addr_q [N];
    logic [N-1:0]                w_q;
    logic [N-1:0]                range_mask;

    // full/empty come from count so head==tail is unambiguous
    assign full         = count == ENTRIES;
    assign empty        = count == '0;
    assign alloc_grant  = alloc_req && !full && !flush;
    assign valid_commit = commit && !empty && !flush;
    assign alloc_id     = tail;
    assign query_addr   = addr_q[query_id];
    assign query_w      = w_q[query_id];

    // flush snaps head onto tail so IDs stay monotonic across a flush
    rob_ptr_counter #(.W(ID_SIZE)) u_head (
        .clk      (clk),
        .reset    (reset),
        .inc      (valid_commit),
        .load     (flush),
        .load_val (tail),
        .ptr      (head)
    );

    rob_ptr_counter #(.W(ID_SIZE)) u_tail (
        .clk      (clk),
        .reset    (reset),
        .inc      (alloc_grant),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (tail)
    );

    // occupancy, busy map and sticky underflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count        <= '0;
            busy         <= '0;
            commit_error <= 1'b0;
        end else begin
            if (commit && empty && !flush) commit_error <= 1'b1;
            if (flush) begin
                count <= '0;
                busy  <= '0;
            end else begin
                count <= count + (ID_SIZE+1)'(alloc_grant) - (ID_SIZE+1)'(valid_commit);
                if (alloc_grant) busy[tail] <= 1'b1;
                if (valid_commit) busy[head] <= 1'b0;
            end
        end
    end

    // destination table written at allocation; retired entries keep stale data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) addr_q[i] <= '0;
            w_q <= '0;
        end else if (alloc_grant) begin
            addr_q[tail] <= alloc_dest_addr;
            w_q[tail]    <= alloc_w;
        end
    end

    // expected busy pattern: the circular window of count entries starting at head
    always_comb begin
        range_mask = '0;
        for (int i = 0; i < N; i++)
            range_mask[i] = ((ID_SIZE+1)'(ID_SIZE'(ID_SIZE'(i) - head))) < count;
    end

    busy_consistent: assert property (@(posedge clk) disable iff (!reset)
        popcount(64'(busy)) == int'(count) && busy == range_mask);

endmodule

// File: tb/tb_rob_allocator.sv
// tb_rob_allocator: table-driven check of rob_allocator with 4 entries
module tb_rob_allocator;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       alloc_req = 1'b0;
    logic [4:0] alloc_dest_addr = '0;
    logic       alloc_w = 1'b0;
    logic       alloc_grant;
    logic [1:0] alloc_id;
    logic [1:0] tail;
    logic       commit = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] query_id = '0;
    logic [4:0] query_addr;
    logic       query_w;
    logic [3:0] busy;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       commit_error;

    int errors = 0;
    int checks = 0;

    rob_allocator #(.ID_SIZE(2), .REG_ADDRESS_SIZE(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .alloc_req       (alloc_req),
        .alloc_dest_addr (alloc_dest_addr),
        .alloc_w         (alloc_w),
        .alloc_grant     (alloc_grant),
        .alloc_id        (alloc_id),
        .tail            (tail),
        .commit          (commit),
        .flush           (flush),
        .query_id        (query_id),
        .query_addr      (query_addr),
        .query_w         (query_w),
        .busy            (busy),
        .count           (count),
        .full            (full),
        .empty           (empty),
        .commit_error    (commit_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic [4:0] dest;
        logic       w;
        logic       cmt;
        logic       fl;
        logic [1:0] qid;
        logic       g;
        logic [1:0] id;
        int         cnt;
        logic [3:0] bsy;
        logic       err;
        int         qa;
        logic       qw;
    } vec_t;

    vec_t vecs [33];

    function automatic vec_t v(logic req, logic [4:0] dest, logic w, logic cmt, logic fl,
                               logic [1:0] qid, logic g, logic [1:0] id, int cnt,
                               logic [3:0] bsy, logic err, int qa, logic qw);
        vec_t r;
        r.req = req; r.dest = dest; r.w = w; r.cmt = cmt; r.fl = fl; r.qid = qid;
        r.g = g; r.id = id; r.cnt = cnt; r.bsy = bsy; r.err = err; r.qa = qa; r.qw = qw;
        return r;
    endfunction

    task automatic chk(string name, int row, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
        end
    endtask

    task automatic run_rows(int lo, int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            alloc_req = vecs[i].req; alloc_dest_addr = vecs[i].dest; alloc_w = vecs[i].w;
            commit = vecs[i].cmt; flush = vecs[i].fl; query_id = vecs[i].qid;
            #1;
            chk("alloc_grant", i, int'(alloc_grant), int'(vecs[i].g));
            chk("alloc_id", i, int'(alloc_id), int'(vecs[i].id));
            chk("tail", i, int'(tail), int'(vecs[i].id));
            chk("count", i, int'(count), vecs[i].cnt);
            chk("busy", i, int'(busy), int'(vecs[i].bsy));
            chk("full", i, int'(full), int'(vecs[i].cnt == 4));
            chk("empty", i, int'(empty), int'(vecs[i].cnt == 0));
            chk("commit_error", i, int'(commit_error), int'(vecs[i].err));
            if (vecs[i].qa >= 0) begin
                chk("query_addr", i, int'(query_addr), vecs[i].qa);
                chk("query_w", i, int'(query_w), int'(vecs[i].qw));
            end
        end
    endtask

    initial begin
        //          req dst w cmt fl qid  g id cnt busy     err qa  qw
        vecs[0]  = v(0,  0, 0, 0, 0, 0,   0, 0, 0, 4'b0000, 0, 0,  0);
        vecs[1]  = v(1,  3, 1, 0, 0, 0,   1, 0, 0, 4'b0000, 0, -1, 0);
        vecs[2]  = v(1,  4, 1, 0, 0, 0,   1, 1, 1, 4'b0001, 0, -1, 0);
        vecs[3]  = v(1,  5, 1, 0, 0, 0,   1, 2, 2, 4'b0011, 0, -1, 0);
        vecs[4]  = v(1,  6, 1, 0, 0, 0,   1, 3, 3, 4'b0111, 0, -1, 0);
        vecs[5]  = v(1,  7, 1, 0, 0, 2,   0, 0, 4, 4'b1111, 0, 5,  1);
        vecs[6]  = v(1,  7, 1, 1, 0, 0,   0, 0, 4, 4'b1111, 0, 3,  1);
        vecs[7]  = v(1,  7, 0, 0, 0, 3,   1, 0, 3, 4'b1110, 0, 6,  1);
        vecs[8]  = v(0,  0, 0, 0, 0, 0,   0, 1, 4, 4'b1111, 0, 7,  0);
        vecs[9]  = v(0,  0, 0, 1, 0, 0,   0, 1, 4, 4'b1111, 0, -1, 0);
        vecs[10] = v(0,  0, 0, 1, 0, 0,   0, 1, 3, 4'b1101, 0, -1, 0);
        vecs[11] = v(1,  9, 1, 1, 0, 0,   1, 1, 2, 4'b1001, 0, -1, 0);
        vecs[12] = v(0,  0, 0, 0, 0, 1,   0, 2, 2, 4'b0011, 0, 9,  1);
        vecs[13] = v(0,  0, 0, 1, 0, 0,   0, 2, 2, 4'b0011, 0, -1, 0);
        vecs[14] = v(0,  0, 0, 1, 0, 0,   0, 2, 1, 4'b0010, 0, -1, 0);
        vecs[15] = v(0,  0, 0, 1, 0, 0,   0, 2, 0, 4'b0000, 0, -1, 0);
        vecs[16] = v(0,  0, 0, 0, 0, 0,   0, 2, 0, 4'b0000, 1, -1, 0);
        vecs[17] = v(1, 13, 1, 0, 0, 0,   1, 2, 0, 4'b0000, 1, -1, 0);
        vecs[18] = v(0,  0, 0, 1, 0, 2,   0, 3, 1, 4'b0100, 1, 13, 1);
        vecs[19] = v(1,  0, 0, 0, 1, 0,   0, 3, 0, 4'b0000, 1, -1, 0);
        vecs[20] = v(0,  0, 0, 0, 0, 0,   0, 3, 0, 4'b0000, 1, -1, 0);
        vecs[21] = v(1, 10, 1, 0, 0, 0,   1, 3, 0, 4'b0000, 1, -1, 0);
        vecs[22] = v(1, 11, 1, 0, 0, 0,   1, 0, 1, 4'b1000, 1, -1, 0);
        vecs[23] = v(1, 12, 1, 0, 0, 0,   1, 1, 2, 4'b1001, 1, -1, 0);
        vecs[24] = v(1,  1, 1, 0, 0, 0,   1, 0, 0, 4'b0000, 0, 0,  0);
        vecs[25] = v(1,  2, 0, 0, 0, 0,   1, 1, 1, 4'b0001, 0, -1, 0);
        vecs[26] = v(1,  3, 1, 0, 0, 0,   1, 2, 2, 4'b0011, 0, -1, 0);
        vecs[27] = v(1,  4, 1, 0, 1, 0,   0, 3, 3, 4'b0111, 0, -1, 0);
        vecs[28] = v(0,  0, 0, 0, 0, 0,   0, 3, 0, 4'b0000, 0, -1, 0);
        vecs[29] = v(1,  8, 1, 0, 0, 0,   1, 3, 0, 4'b0000, 0, -1, 0);
        vecs[30] = v(0,  0, 0, 0, 0, 3,   0, 0, 1, 4'b1000, 0, 8,  1);
        vecs[31] = v(0,  0, 0, 1, 0, 0,   0, 0, 1, 4'b1000, 0, -1, 0);
        vecs[32] = v(0,  0, 0, 0, 0, 0,   0, 0, 0, 4'b0000, 0, -1, 0);

        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_rows(0, 24);

        // asynchronous reset in the middle of a cycle with three entries in flight
        @(negedge clk);
        alloc_req = 1'b0; commit = 1'b0; flush = 1'b0; query_id = 2'd0;
        #1;
        chk("pre_reset_count", 100, int'(count), 3);
        chk("pre_reset_busy", 100, int'(busy), 4'b1011);
        chk("pre_reset_tail", 100, int'(tail), 2);
        chk("pre_reset_query", 100, int'(query_addr), 11);
        #1;
        reset = 1'b0;
        #1;
        chk("async_count", 101, int'(count), 0);
        chk("async_busy", 101, int'(busy), 0);
        chk("async_tail", 101, int'(tail), 0);
        chk("async_empty", 101, int'(empty), 1);
        chk("async_full", 101, int'(full), 0);
        chk("async_err", 101, int'(commit_error), 0);
        chk("async_grant", 101, int'(alloc_grant), 0);
        chk("async_query", 101, int'(query_addr), 0);
        @(negedge clk);
        reset = 1'b1;

        run_rows(24, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
